// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_pkg
//  Purpose : Shared types and the prefix-cell operator for the Kogge-Stone
//            adder datapath.
//  Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

    localparam int MAX_ADDER_WIDTH = 64;

    // Generate/propagate pair carried through every prefix level
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix cell: merges a higher-order group (hi) with the adjacent lower group (lo)
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t w_res;
        w_res.g = hi.g | (hi.p & lo.g);
        w_res.p = hi.p & lo.p;
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_level_stage.sv
`default_nettype none
// ============================================================================
//  Module  : prefix_level_stage
//  Purpose : One Kogge-Stone prefix level: combines each bit with the bit
//            DISTANCE below it, then registers the result under an enable.
//  Rev     : 1.0  initial release
// ============================================================================
module prefix_level_stage
    import adder_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DISTANCE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_enable,
    input  gp_t  [WIDTH-1:0] i_gp,
    output gp_t  [WIDTH-1:0] o_gp
);

    gp_t [WIDTH-1:0] w_gp_next;
    gp_t [WIDTH-1:0] r_gp;

    // Bits below DISTANCE already span down to bit 0 and pass through unchanged
    always_comb begin
        w_gp_next = i_gp;
        for (int i = DISTANCE; i < WIDTH; i++) begin
            w_gp_next[i] = gp_combine(i_gp[i], i_gp[i-DISTANCE]);
        end
    end

    // Level register; holds its contents while the pipeline is stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gp <= '0;
        end else if (i_enable) begin
            r_gp <= w_gp_next;
        end
    end

    assign o_gp = r_gp;

endmodule
`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
//  Module  : pipelined_prefix_adder
//  Purpose : Pipelined Kogge-Stone adder/subtractor with valid/ready flow
//            control, carry-out and signed overflow. LEVELS+2 stages deep.
//  Rev     : 1.0  initial release
// ============================================================================
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_subtract,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int STAGES = LEVELS + 2;

    if (WIDTH < 4 || WIDTH > MAX_ADDER_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("pipelined_prefix_adder: WIDTH must be a power of two in 4..%0d", MAX_ADDER_WIDTH);
    end

    logic              w_advance;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin;
    gp_t  [WIDTH-1:0]  w_gp_s0;
    gp_t  [WIDTH-1:0]  w_gp_fold;
    gp_t  [WIDTH-1:0]  w_gp     [0:LEVELS];
    logic [WIDTH-1:0]  w_carry;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;
    logic              w_ovf;
    logic              w_unused_p;

    logic [STAGES-1:0] r_valid;
    gp_t  [WIDTH-1:0]  r_gp0;
    logic [WIDTH-1:0]  r_p0     [0:LEVELS];
    logic              r_cin    [0:LEVELS];
    logic              r_a_msb  [0:LEVELS];
    logic              r_b_msb  [0:LEVELS];
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_ovf;

    // One global enable: the whole pipe moves unless a result is waiting unread
    assign w_advance = out_ready | ~r_valid[STAGES-1];
    assign in_ready  = w_advance;

    // Subtraction is A + ~B + 1, so B is inverted and carry-in forced high
    assign w_b_eff = in_b ^ {WIDTH{in_subtract}};
    assign w_cin   = in_subtract | in_carry;

    // Bit-level generate/propagate of the effective operands
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gp_s0[i].g = in_a[i] & w_b_eff[i];
            w_gp_s0[i].p = in_a[i] ^ w_b_eff[i];
        end
    end

    // Valid shift chain; bubbles travel with the data so order is preserved
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid <= {r_valid[STAGES-2:0], in_valid};
        end
    end

    // S0 register plus the side data (raw propagate, carry-in, MSBs) that rides alongside the prefix levels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gp0 <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                r_p0[k]    <= '0;
                r_cin[k]   <= 1'b0;
                r_a_msb[k] <= 1'b0;
                r_b_msb[k] <= 1'b0;
            end
        end else if (w_advance) begin
            r_gp0      <= w_gp_s0;
            r_p0[0]    <= in_a ^ w_b_eff;
            r_cin[0]   <= w_cin;
            r_a_msb[0] <= in_a[WIDTH-1];
            r_b_msb[0] <= w_b_eff[WIDTH-1];
            for (int k = 1; k <= LEVELS; k++) begin
                r_p0[k]    <= r_p0[k-1];
                r_cin[k]   <= r_cin[k-1];
                r_a_msb[k] <= r_a_msb[k-1];
                r_b_msb[k] <= r_b_msb[k-1];
            end
        end
    end

    // Fold carry-in into bit 0 as a generate from position -1, so group G[i:0] becomes c_(i+1)
    always_comb begin
        w_gp_fold      = r_gp0;
        w_gp_fold[0].g = r_gp0[0].g | (r_gp0[0].p & r_cin[0]);
    end

    assign w_gp[0] = w_gp_fold;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        prefix_level_stage #(
            .WIDTH    (WIDTH),
            .DISTANCE (1 << k)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_enable (w_advance),
            .i_gp     (w_gp[k]),
            .o_gp     (w_gp[k+1])
        );
    end

    // Carries from the completed prefix tree; group propagates are not needed past the last level
    always_comb begin
        w_carry[0] = r_cin[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
            w_carry[i] = w_gp[LEVELS][i-1].g;
        end
        w_sum  = r_p0[LEVELS] ^ w_carry;
        w_cout = w_gp[LEVELS][WIDTH-1].g;
        w_ovf  = (r_a_msb[LEVELS] == r_b_msb[LEVELS]) && (w_sum[WIDTH-1] != r_a_msb[LEVELS]);
        w_unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_unused_p = w_unused_p ^ w_gp[LEVELS][i].p;
        end
    end

    // Result register; stays stable while the consumer is not ready
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_advance) begin
            r_sum   <= w_sum;
            r_carry <= w_cout;
            r_ovf   <= w_ovf;
        end
    end

    assign out_valid    = r_valid[STAGES-1];
    assign out_sum      = r_sum;
    assign out_carry    = r_carry;
    assign out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipelined_prefix_adder
//  Purpose : Self-checking bench for pipelined_prefix_adder at WIDTH 32/8/64
//            with a queue-based scoreboard per instance.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipelined_prefix_adder;

    localparam int NDUT = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid_v  [NDUT];
    logic        out_ready_v [NDUT];
    logic [63:0] a_v         [NDUT];
    logic [63:0] b_v         [NDUT];
    logic        sub_v       [NDUT];
    logic        cin_v       [NDUT];
    logic        in_ready_v  [NDUT];
    logic        out_valid_v [NDUT];
    logic        carry_v     [NDUT];
    logic        ovf_v       [NDUT];
    logic [63:0] sum_v       [NDUT];
    wire  [31:0] sum0;
    wire  [7:0]  sum1;
    wire  [63:0] sum2;

    logic [65:0] q0[$];
    logic [65:0] q1[$];
    logic [65:0] q2[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int out_cnt   [NDUT];
    int first_out [NDUT];
    int last_out  [NDUT];

    always #5 clock = ~clock;

    pipelined_prefix_adder #(.WIDTH(32)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(a_v[0][31:0]), .in_b(b_v[0][31:0]), .in_subtract(sub_v[0]), .in_carry(cin_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_sum(sum0),
        .out_carry(carry_v[0]), .out_overflow(ovf_v[0]));

    pipelined_prefix_adder #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(a_v[1][7:0]), .in_b(b_v[1][7:0]), .in_subtract(sub_v[1]), .in_carry(cin_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_sum(sum1),
        .out_carry(carry_v[1]), .out_overflow(ovf_v[1]));

    pipelined_prefix_adder #(.WIDTH(64)) u_dut64 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(a_v[2]), .in_b(b_v[2]), .in_subtract(sub_v[2]), .in_carry(cin_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_sum(sum2),
        .out_carry(carry_v[2]), .out_overflow(ovf_v[2]));

    assign sum_v[0] = {32'd0, sum0};
    assign sum_v[1] = {56'd0, sum1};
    assign sum_v[2] = sum2;

    function automatic int wid(input int i);
        return (i == 0) ? 32 : ((i == 1) ? 8 : 64);
    endfunction

    function automatic logic [63:0] mask64(input int i);
        logic [64:0] m;
        m = (65'd1 << wid(i)) - 65'd1;
        return m[63:0];
    endfunction

    // Reference model: plain wide arithmetic, returns {overflow, carry, sum}
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic sub, input logic cin);
        logic [64:0] m, aa, bb, full;
        logic [63:0] s;
        logic        c, v;
        m    = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & m;
        bb   = {1'b0, (sub ? ~b : b)} & m;
        full = aa + bb + {64'd0, (sub ? 1'b1 : cin)};
        s    = full[63:0] & m[63:0];
        c    = full[w];
        v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {v, c, s};
    endfunction

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input logic [65:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i, output logic [65:0] e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic sb_clear();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Scoreboard step, run on every falling edge: handshakes seen here complete at the next rising edge
    task automatic mon_step();
        logic [65:0] e;
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            if (reset_n) begin
                if (in_valid_v[i] && in_ready_v[i])
                    sb_push(i, model(wid(i), a_v[i], b_v[i], sub_v[i], cin_v[i]));
                if (out_valid_v[i] && out_ready_v[i]) begin
                    checks++;
                    out_cnt[i]++;
                    if (first_out[i] < 0) first_out[i] = cyc;
                    last_out[i] = cyc;
                    if (sb_size(i) == 0) begin
                        errors++;
                        $display("FAIL sb_extra dut%0d: got sum=%h c=%b v=%b, required no result", i, sum_v[i], carry_v[i], ovf_v[i]);
                    end else begin
                        sb_pop(i, e);
                        if ({ovf_v[i], carry_v[i], sum_v[i]} !== e) begin
                            errors++;
                            $display("FAIL sb_result dut%0d: got sum=%h c=%b v=%b, required sum=%h c=%b v=%b",
                                     i, sum_v[i], carry_v[i], ovf_v[i], e[63:0], e[64], e[65]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_beat(input int i, input logic [63:0] a, input logic [63:0] b,
                             input logic sub, input logic cin);
        int   t;
        logic ok;
        a_v[i] = a; b_v[i] = b; sub_v[i] = sub; cin_v[i] = cin;
        in_valid_v[i] = 1'b1;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 100) begin
            @(negedge clock);
            ok = in_ready_v[i];
            @(posedge clock); #1;
            t++;
        end
        in_valid_v[i] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1 within 100 cycles", i);
        end
    endtask

    task automatic drain(input int i);
        int t;
        t = 0;
        in_valid_v[i]  = 1'b0;
        out_ready_v[i] = 1'b1;
        while (sb_size(i) != 0 && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        @(posedge clock); #1;
        checks++;
        if (sb_size(i) != 0) begin
            errors++;
            $display("FAIL drain dut%0d: %0d results outstanding, required 0", i, sb_size(i));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1;
            a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
            out_cnt[i] = 0; first_out[i] = -1; last_out[i] = -1;
        end
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_flags dut%0d: out_valid=%b in_ready=%b, required 0/1", i, out_valid_v[i], in_ready_v[i]);
            end
            checks++;
            if (sum_v[i] !== 64'd0 || carry_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_data dut%0d: sum=%h c=%b v=%b, required all 0", i, sum_v[i], carry_v[i], ovf_v[i]);
            end
        end
    endtask

    task automatic test_latency();
        send_beat(0, 64'h0000_0001, 64'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b after 6 edges, required 0", out_valid_v[0]);
        end
        @(posedge clock); #1;
        checks++;
        if (out_valid_v[0] !== 1'b1 || sum0 !== 32'd0 || carry_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_7: valid=%b sum=%h c=%b v=%b, required 1 00000000 1 0",
                     out_valid_v[0], sum0, carry_v[0], ovf_v[0]);
        end
        drain(0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        v;
    } edge_t;

    task automatic test_edge_cases();
        edge_t tbl[6];
        int    t;
        tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        for (int n = 0; n < 6; n++) begin
            send_beat(0, {32'd0, tbl[n].a}, {32'd0, tbl[n].b}, tbl[n].sub, tbl[n].cin);
            t = 0;
            while (out_valid_v[0] !== 1'b1 && t < 20) begin
                @(posedge clock); #1;
                t++;
            end
            checks++;
            if (out_valid_v[0] !== 1'b1 || sum0 !== tbl[n].s || carry_v[0] !== tbl[n].c || ovf_v[0] !== tbl[n].v) begin
                errors++;
                $display("FAIL edge_case%0d: valid=%b sum=%h c=%b v=%b, required 1 %h %b %b",
                         n, out_valid_v[0], sum0, carry_v[0], ovf_v[0], tbl[n].s, tbl[n].c, tbl[n].v);
            end
            drain(0);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = out_cnt[0];
        first_out[0] = -1;
        out_ready_v[0] = 1'b1;
        for (int n = 0; n < 100; n++)
            send_beat(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(0);
        checks++;
        if (out_cnt[0] - base != 100 || last_out[0] - first_out[0] != 99) begin
            errors++;
            $display("FAIL back_to_back: %0d results over %0d cycles, required 100 over 99",
                     out_cnt[0] - base, last_out[0] - first_out[0]);
        end
    endtask

    task automatic test_stall();
        logic [63:0] held;
        int          base;
        int          bad_rdy;
        int          bad_sum;
        base = out_cnt[0];
        out_ready_v[0] = 1'b0;
        for (int n = 0; n < 7; n++)
            send_beat(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: out_valid=%b in_ready=%b, required 1/0", out_valid_v[0], in_ready_v[0]);
        end
        held = sum_v[0];
        a_v[0] = 64'h0000_0000_DEAD_BEEF; b_v[0] = 64'h0000_0000_0000_1111;
        sub_v[0] = 1'b0; cin_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        bad_rdy = 0;
        bad_sum = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) bad_rdy++;
            if (sum_v[0] !== held) bad_sum++;
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL stall_ready: %0d cycles with in_ready=1 or out_valid=0, required 0", bad_rdy);
        end
        checks++;
        if (bad_sum != 0) begin
            errors++;
            $display("FAIL stall_hold: out_sum moved in %0d cycles (now %h), required stable %h", bad_sum, sum_v[0], held);
        end
        out_ready_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        drain(0);
        checks++;
        if (out_cnt[0] - base != 8) begin
            errors++;
            $display("FAIL stall_count: %0d results, required 8", out_cnt[0] - base);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready_v[0] = 1'b1;
        for (int n = 0; n < 9; n++)
            send_beat(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        reset_n = 1'b0;
        sb_clear();
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b during reset, required 0", out_valid_v[0]);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        checks++;
        if (in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b after release, required 1", in_ready_v[0]);
        end
        stale = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_valid_v[0] !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_stale: out_valid=1 in %0d cycles after reset, required 0", stale);
        end
    endtask

    task automatic test_random_toggle(input int i, input int n);
        logic        pend;
        logic [63:0] m, a;
        int          mode;
        m    = mask64(i);
        pend = 1'b0;
        repeat (n) begin
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    mode = $urandom_range(0, 3);
                    a    = {$urandom, $urandom} & m;
                    a_v[i] = a;
                    case (mode)
                        0: begin b_v[i] = ~a & m; sub_v[i] = 1'b0; cin_v[i] = 1'b1; end
                        1: begin b_v[i] = a; sub_v[i] = 1'b1; cin_v[i] = 1'($urandom_range(0, 1)); end
                        default: begin
                            b_v[i]   = {$urandom, $urandom} & m;
                            sub_v[i] = 1'($urandom_range(0, 1));
                            cin_v[i] = 1'($urandom_range(0, 1));
                        end
                    endcase
                    in_valid_v[i] = 1'b1;
                end else begin
                    in_valid_v[i] = 1'b0;
                end
            end
            out_ready_v[i] = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            pend = in_valid_v[i] && !in_ready_v[i];
            @(posedge clock); #1;
        end
        drain(i);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                mon_step();
            end
        join_none
        test_reset();
        test_latency();
        test_edge_cases();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random_toggle(0, 300);
        test_random_toggle(1, 300);
        test_random_toggle(2, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
